thread_scheduler: RTL

- Sits directly downstream of thread_manager. thread_manager launches threads into per-thread slots.
- The scheduler tracks each slot's state and picks ready threads round-robin.
- It issues one {tid, pc} at a time to the vector fetch stage over a valid/ready handshake.
- The pipeline returns each issued thread to the scheduler through resume (run again at a new PC) or retire (thread finished, slot freed).

---
 rtl/thread_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/thread_scheduler.sv | 126 ++++++++++++
 3 files changed

// File: rtl/thread_pkg.sv
// Shared thread-slot definitions for thread_manager and thread_scheduler.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package thread_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READY = 2'd1,
    SENT  = 2'd2
  } thread_state_e;

  localparam int DEF_NUM_THREADS = 8;
  localparam int DEF_PC_WIDTH    = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority search: first asserted req at or after ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether to act on the grant.
module rr_arbiter #(
  parameter int N = 8,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic          grant_valid,
  output logic [PW-1:0] grant_idx
);

  logic [PW-1:0] cand;

  // Scan offsets from farthest to nearest so the nearest requester wins last.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = ptr + i[PW-1:0];
      if (req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/thread_scheduler.sv
// Tracks per-slot thread state and issues READY threads round-robin to fetch.
// Latency: launch or resume to issue_valid is 2 cycles with an empty issue register.
// Backpressure: issue_tid/issue_pc hold while issue_valid && !issue_ready; launch stalls via launch_ready.
module thread_scheduler
  import thread_pkg::*;
#(
  parameter int NUM_THREADS = DEF_NUM_THREADS,
  parameter int PC_WIDTH    = DEF_PC_WIDTH,
  localparam int TID_WIDTH  = $clog2(NUM_THREADS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   launch_valid,
  input  logic [TID_WIDTH-1:0]   launch_tid,
  input  logic [PC_WIDTH-1:0]    launch_pc,
  output logic                   launch_ready,
  output logic                   issue_valid,
  output logic [TID_WIDTH-1:0]   issue_tid,
  output logic [PC_WIDTH-1:0]    issue_pc,
  input  logic                   issue_ready,
  input  logic                   resume_valid,
  input  logic [TID_WIDTH-1:0]   resume_tid,
  input  logic [PC_WIDTH-1:0]    resume_pc,
  input  logic                   retire_valid,
  input  logic [TID_WIDTH-1:0]   retire_tid,
  output logic [NUM_THREADS-1:0] thread_busy,
  output logic                   error_pulse
);

  thread_state_e          st_q [NUM_THREADS];
  thread_state_e          st_d [NUM_THREADS];
  logic [PC_WIDTH-1:0]    pc_q [NUM_THREADS];
  logic [PC_WIDTH-1:0]    pc_d [NUM_THREADS];
  logic [TID_WIDTH-1:0]   rr_ptr;
  logic [NUM_THREADS-1:0] ready_vec;
  logic [NUM_THREADS-1:0] busy_d;
  logic                   grant_valid;
  logic [TID_WIDTH-1:0]   grant_idx;
  logic                   issue_load;
  logic                   launch_fire;
  logic                   collide;
  logic                   resume_ok;
  logic                   retire_ok;
  logic                   err_d;

  assign launch_ready = (st_q[launch_tid] == IDLE);
  assign launch_fire  = launch_valid && launch_ready;
  assign issue_load   = !issue_valid || issue_ready;

  // A thread still sitting in the issue register has not reached the pipeline,
  // so any resume/retire naming it is bogus. Same-tid resume+retire: retire wins.
  assign collide   = resume_valid && retire_valid && (resume_tid == retire_tid);
  assign retire_ok = retire_valid && (st_q[retire_tid] == SENT)
                     && !(issue_valid && (issue_tid == retire_tid));
  assign resume_ok = resume_valid && !collide && (st_q[resume_tid] == SENT)
                     && !(issue_valid && (issue_tid == resume_tid));
  assign err_d     = (resume_valid && !resume_ok) || (retire_valid && !retire_ok);

  // Request vector for the arbiter: slots waiting to be issued.
  always_comb begin
    ready_vec = '0;
    for (int i = 0; i < NUM_THREADS; i++) ready_vec[i] = (st_q[i] == READY);
  end

  rr_arbiter #(.N(NUM_THREADS)) u_arb (
    .req         (ready_vec),
    .ptr         (rr_ptr),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // Next slot state; launch (IDLE), grant (READY) and resume/retire (SENT) never hit the same slot.
  always_comb begin
    st_d = st_q;
    pc_d = pc_q;
    if (launch_fire) begin
      st_d[launch_tid] = READY;
      pc_d[launch_tid] = launch_pc;
    end
    if (issue_load && grant_valid) st_d[grant_idx] = SENT;
    if (resume_ok) begin
      st_d[resume_tid] = READY;
      pc_d[resume_tid] = resume_pc;
    end
    if (retire_ok) st_d[retire_tid] = IDLE;
    busy_d = '0;
    for (int i = 0; i < NUM_THREADS; i++) busy_d[i] = (st_d[i] != IDLE);
  end

  // Slot state, PCs, busy mirror and error pulse all advance on the same edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_THREADS; i++) begin
        st_q[i] <= IDLE;
        pc_q[i] <= '0;
      end
      thread_busy <= '0;
      error_pulse <= 1'b0;
    end else begin
      st_q        <= st_d;
      pc_q        <= pc_d;
      thread_busy <= busy_d;
      error_pulse <= err_d;
    end
  end

  // Issue register: reload when empty or being accepted; pointer moves past each grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      issue_valid <= 1'b0;
      issue_tid   <= '0;
      issue_pc    <= '0;
      rr_ptr      <= '0;
    end else if (issue_load) begin
      if (grant_valid) begin
        issue_valid <= 1'b1;
        issue_tid   <= grant_idx;
        issue_pc    <= pc_q[grant_idx];
        rr_ptr      <= grant_idx + TID_WIDTH'(1);
      end else begin
        issue_valid <= 1'b0;
      end
    end
  end

endmodule
